ifm_window_feeder: RTL and testbench

//  Upstream feeder for the 3x3 convolution stage. Loads one IMG_H x IMG_W 8-bit
//  IFM frame (raster, 1 pixel/cycle) and 9 serial kernel weights. Then streams

---
 rtl/ifm_window_feeder.sv | 208 ++++++++++++++++++++
 tb/tb_ifm_window_feeder.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifm_window_feeder.sv
// Buffers one IMG_H x IMG_W frame plus nine kernel weights, then streams every
// valid 3x3 window on consecutive cycles to the convolution stage.
module ifm_window_feeder #(
    parameter int IMG_W  = 7,
    parameter int IMG_H  = 7,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_pix_valid,
    input  logic [DATA_W-1:0] i_pix_data,
    output logic              o_pix_ready,
    input  logic              i_wt_valid,
    input  logic [DATA_W-1:0] i_wt_data,
    output logic              o_wt_ready,
    output logic              o_win_valid,
    output logic [DATA_W-1:0] o_win_1,
    output logic [DATA_W-1:0] o_win_2,
    output logic [DATA_W-1:0] o_win_3,
    output logic [DATA_W-1:0] o_win_4,
    output logic [DATA_W-1:0] o_win_5,
    output logic [DATA_W-1:0] o_win_6,
    output logic [DATA_W-1:0] o_win_7,
    output logic [DATA_W-1:0] o_win_8,
    output logic [DATA_W-1:0] o_win_9,
    output logic              o_weight_valid,
    output logic [DATA_W-1:0] o_weight_1,
    output logic [DATA_W-1:0] o_weight_2,
    output logic [DATA_W-1:0] o_weight_3,
    output logic [DATA_W-1:0] o_weight_4,
    output logic [DATA_W-1:0] o_weight_5,
    output logic [DATA_W-1:0] o_weight_6,
    output logic [DATA_W-1:0] o_weight_7,
    output logic [DATA_W-1:0] o_weight_8,
    output logic [DATA_W-1:0] o_weight_9,
    output logic              o_frame_done
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int NWIN = (IMG_H - 2) * (IMG_W - 2);
    localparam int IW   = $clog2(NPIX);
    localparam int PCW  = $clog2(NPIX + 1);
    localparam int RW   = $clog2(IMG_H);
    localparam int CW   = $clog2(IMG_W);
    localparam int WCW  = $clog2(NWIN + 1);

    typedef enum logic [1:0] {S_LOAD, S_EMIT, S_DONE} state_t;

    state_t            r_state;
    logic [PCW-1:0]    r_pix_cnt;
    logic [3:0]        r_wt_cnt;
    logic [RW-1:0]     r_row;
    logic [CW-1:0]     r_col;
    logic [WCW-1:0]    r_win_cnt;
    logic              r_pix_ready;
    logic              r_wt_ready;
    logic              r_win_valid;
    logic              r_weight_valid;
    logic              r_frame_done;
    logic [DATA_W-1:0] r_frame [NPIX];
    logic [DATA_W-1:0] r_wt    [9];
    logic [DATA_W-1:0] r_win   [9];

    logic              w_pix_accept;
    logic              w_wt_accept;
    logic              w_pix_full;
    logic              w_wt_full;
    logic [IW-1:0]     w_base;
    logic [IW-1:0]     w_idx   [9];

    assign w_pix_accept = i_pix_valid & r_pix_ready;
    assign w_wt_accept  = i_wt_valid & r_wt_ready;
    assign w_pix_full   = (r_pix_cnt == PCW'(NPIX));
    assign w_wt_full    = (r_wt_cnt == 4'd9);

    // (r_row, r_col) always names the next window to present
    always_comb begin
        w_base = IW'(r_row) * IW'(IMG_W) + IW'(r_col);
        for (int k = 0; k < 9; k++) begin
            w_idx[k] = w_base + IW'((k / 3) * IMG_W + (k % 3));
        end
    end

    always_ff @(posedge clk) begin
        if (w_pix_accept) begin
            r_frame[r_pix_cnt[IW-1:0]] <= i_pix_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 9; k++) begin
                r_wt[k] <= '0;
            end
        end else if (w_wt_accept) begin
            r_wt[r_wt_cnt] <= i_wt_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_LOAD;
            r_pix_cnt      <= '0;
            r_wt_cnt       <= '0;
            r_row          <= '0;
            r_col          <= '0;
            r_win_cnt      <= '0;
            r_pix_ready    <= 1'b1;
            r_wt_ready     <= 1'b1;
            r_win_valid    <= 1'b0;
            r_weight_valid <= 1'b0;
            r_frame_done   <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                r_win[k] <= '0;
            end
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_pix_accept) begin
                        r_pix_cnt <= r_pix_cnt + PCW'(1);
                        if (r_pix_cnt == PCW'(NPIX - 1)) begin
                            r_pix_ready <= 1'b0;
                        end
                    end
                    if (w_wt_accept) begin
                        r_wt_cnt <= r_wt_cnt + 4'd1;
                        if (r_wt_cnt == 4'd8) begin
                            r_wt_ready <= 1'b0;
                        end
                    end
                    if (w_pix_full && w_wt_full) begin
                        r_state        <= S_EMIT;
                        r_win_valid    <= 1'b1;
                        r_weight_valid <= 1'b1;
                        r_win_cnt      <= '0;
                        for (int k = 0; k < 9; k++) begin
                            r_win[k] <= r_frame[w_idx[k]];
                        end
                        if (r_col == CW'(IMG_W - 3)) begin
                            r_col <= '0;
                            r_row <= r_row + RW'(1);
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                    end
                end
                S_EMIT: begin
                    r_weight_valid <= 1'b0;
                    if (r_win_cnt == WCW'(NWIN - 1)) begin
                        r_state      <= S_DONE;
                        r_win_valid  <= 1'b0;
                        r_frame_done <= 1'b1;
                    end else begin
                        r_win_cnt <= r_win_cnt + WCW'(1);
                        for (int k = 0; k < 9; k++) begin
                            r_win[k] <= r_frame[w_idx[k]];
                        end
                        if (r_col == CW'(IMG_W - 3)) begin
                            r_col <= '0;
                            r_row <= r_row + RW'(1);
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_state      <= S_LOAD;
                    r_frame_done <= 1'b0;
                    r_pix_cnt    <= '0;
                    r_wt_cnt     <= '0;
                    r_row        <= '0;
                    r_col        <= '0;
                    r_win_cnt    <= '0;
                    r_pix_ready  <= 1'b1;
                    r_wt_ready   <= 1'b1;
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

    assign o_pix_ready    = r_pix_ready;
    assign o_wt_ready     = r_wt_ready;
    assign o_win_valid    = r_win_valid;
    assign o_weight_valid = r_weight_valid;
    assign o_frame_done   = r_frame_done;

    assign o_win_1 = r_win[0];
    assign o_win_2 = r_win[1];
    assign o_win_3 = r_win[2];
    assign o_win_4 = r_win[3];
    assign o_win_5 = r_win[4];
    assign o_win_6 = r_win[5];
    assign o_win_7 = r_win[6];
    assign o_win_8 = r_win[7];
    assign o_win_9 = r_win[8];

    assign o_weight_1 = r_wt[0];
    assign o_weight_2 = r_wt[1];
    assign o_weight_3 = r_wt[2];
    assign o_weight_4 = r_wt[3];
    assign o_weight_5 = r_wt[4];
    assign o_weight_6 = r_wt[5];
    assign o_weight_7 = r_wt[6];
    assign o_weight_8 = r_wt[7];
    assign o_weight_9 = r_wt[8];

endmodule

// File: tb/tb_ifm_window_feeder.sv
// Randomised bench for ifm_window_feeder: loads frames and weights, then compares
// every emitted window against windows computed directly from the loaded frame.
module tb_ifm_window_feeder;

    localparam int IMG_W = 7;
    localparam int IMG_H = 7;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int NWC   = IMG_W - 2;
    localparam int NWIN  = (IMG_H - 2) * (IMG_W - 2);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pixValid = 1'b0;
    logic [7:0] pixData = '0;
    logic       pixReady;
    logic       wtValid = 1'b0;
    logic [7:0] wtData = '0;
    logic       wtReady;
    logic       winValid;
    logic [7:0] win [9];
    logic       weightValid;
    logic [7:0] wts [9];
    logic       frameDone;

    int checks = 0;
    int errors = 0;

    logic [7:0] refPix [NPIX];
    logic [7:0] refWt  [9];

    bit         loadTimeout;
    logic       loadEndWv;
    bit         fullRdySeen;

    logic [7:0] capWin [64][9];
    logic [7:0] capWt  [9];
    int         nWin;
    int         nWv;
    int         firstLat;
    bit         wvFirst;
    bit         capTimeout;
    bit         rdyInEmit;
    logic       fdAtDone;
    logic       wvAtDone;
    logic       rdyAtDone;
    logic       fdAfter;
    logic       rdyAfter;

    always #5 clk = ~clk;

    ifm_window_feeder #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_pix_valid(pixValid), .i_pix_data(pixData), .o_pix_ready(pixReady),
        .i_wt_valid(wtValid), .i_wt_data(wtData), .o_wt_ready(wtReady),
        .o_win_valid(winValid),
        .o_win_1(win[0]), .o_win_2(win[1]), .o_win_3(win[2]),
        .o_win_4(win[3]), .o_win_5(win[4]), .o_win_6(win[5]),
        .o_win_7(win[6]), .o_win_8(win[7]), .o_win_9(win[8]),
        .o_weight_valid(weightValid),
        .o_weight_1(wts[0]), .o_weight_2(wts[1]), .o_weight_3(wts[2]),
        .o_weight_4(wts[3]), .o_weight_5(wts[4]), .o_weight_6(wts[5]),
        .o_weight_7(wts[6]), .o_weight_8(wts[7]), .o_weight_9(wts[8]),
        .o_frame_done(frameDone)
    );

    // Window i sits at top-left (i / NWC, i % NWC); element k is row k/3, col k%3 inside it
    function automatic logic [7:0] expPix(input int i, input int k);
        int r;
        int c;
        r = i / NWC;
        c = i % NWC;
        return refPix[(r + k / 3) * IMG_W + c + (k % 3)];
    endfunction

    // mode 0: pixels and weights together, 1: weights first, 2: pixels first
    task automatic load_frame(input int mode, input int duty);
        int  pi;
        int  wi;
        int  cyc;
        logic pr;
        logic wr;
        pi = 0; wi = 0; cyc = 0;
        loadTimeout = 0; fullRdySeen = 0;
        while ((pi < NPIX || wi < 9) && cyc < 2000) begin
            @(negedge clk);
            if (pi < NPIX) begin
                pixValid = (mode != 1 || wi == 9) && ($urandom_range(99) < duty);
                pixData  = refPix[pi];
            end else begin
                pixValid = (mode == 2);
                pixData  = 8'hEE;
            end
            if (wi < 9) begin
                wtValid = (mode != 2 || pi == NPIX) && ($urandom_range(99) < duty);
                wtData  = refWt[wi];
            end else begin
                wtValid = 1'b0;
            end
            pr = pixReady;
            wr = wtReady;
            if ((pi >= NPIX && pr) || (wi >= 9 && wr)) fullRdySeen = 1;
            @(posedge clk);
            if (pixValid && pr && pi < NPIX) pi++;
            if (wtValid && wr && wi < 9) wi++;
            cyc++;
        end
        if (cyc >= 2000) loadTimeout = 1;
        @(negedge clk);
        loadEndWv = winValid;
        pixValid = 1'b0;
        wtValid  = 1'b0;
    endtask

    task automatic capture(input bit noise);
        capTimeout = 0; nWin = 0; nWv = 0; wvFirst = 0; rdyInEmit = 0; firstLat = 0;
        do begin
            @(negedge clk);
            firstLat++;
        end while (!winValid && firstLat < 20);
        if (!winValid) begin
            capTimeout = 1;
            return;
        end
        while (winValid && nWin < 64) begin
            for (int k = 0; k < 9; k++) capWin[nWin][k] = win[k];
            if (weightValid) begin
                nWv++;
                if (nWin == 0) begin
                    wvFirst = 1;
                    for (int k = 0; k < 9; k++) capWt[k] = wts[k];
                end
            end
            if (pixReady || wtReady) rdyInEmit = 1;
            if (noise) begin
                pixValid = 1'b1; pixData = 8'($urandom);
                wtValid  = 1'b1; wtData  = 8'($urandom);
            end
            nWin++;
            @(negedge clk);
        end
        pixValid  = 1'b0;
        wtValid   = 1'b0;
        fdAtDone  = frameDone;
        wvAtDone  = winValid;
        rdyAtDone = pixReady | wtReady;
        @(negedge clk);
        fdAfter  = frameDone;
        rdyAfter = pixReady & wtReady;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if (pixReady !== 1'b1 || wtReady !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready got pix=%b wt=%b exp 1 1", pixReady, wtReady);
        end
        checks++;
        if (winValid !== 1'b0 || weightValid !== 1'b0 || frameDone !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags got win=%b wv=%b fd=%b exp 0 0 0", winValid, weightValid, frameDone);
        end
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (win[k] !== 8'd0 || wts[k] !== 8'd0) begin
                errors++;
                $display("[TB] FAIL reset_data k=%0d got win=%h wt=%h exp 00 00", k, win[k], wts[k]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (pixReady !== 1'b1 || winValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset got ready=%b win=%b exp 1 0", pixReady, winValid);
        end
    endtask

    task automatic test_basic;
        for (int p = 0; p < NPIX; p++) refPix[p] = 8'(p);
        for (int k = 0; k < 9; k++) refWt[k] = 8'(k + 1);
        load_frame(0, 100);
        capture(0);
        checks++;
        if (loadTimeout || capTimeout || loadEndWv !== 1'b0 || firstLat != 1) begin
            errors++;
            $display("[TB] FAIL basic_latency got lat=%0d early=%b to=%0d/%0d exp lat=1", firstLat, loadEndWv, loadTimeout, capTimeout);
        end
        checks++;
        if (nWin != NWIN) begin
            errors++;
            $display("[TB] FAIL basic_count got %0d exp %0d", nWin, NWIN);
        end
        for (int i = 0; i < NWIN; i++) begin
            int bad;
            bad = -1;
            for (int k = 0; k < 9; k++) if (capWin[i][k] !== expPix(i, k)) bad = k;
            checks++;
            if (bad >= 0) begin
                errors++;
                $display("[TB] FAIL basic_win%0d k=%0d got %0d exp %0d", i, bad, capWin[i][bad], expPix(i, bad));
            end
        end
        checks++;
        if (capWin[0][3] !== 8'd7 || capWin[5][0] !== 8'd7 || capWin[24][8] !== 8'd48) begin
            errors++;
            $display("[TB] FAIL basic_corners got %0d %0d %0d exp 7 7 48", capWin[0][3], capWin[5][0], capWin[24][8]);
        end
        checks++;
        if (nWv != 1 || !wvFirst) begin
            errors++;
            $display("[TB] FAIL basic_weight_valid got count=%0d first=%0d exp 1 1", nWv, wvFirst);
        end
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (capWt[k] !== 8'(k + 1)) begin
                errors++;
                $display("[TB] FAIL basic_weight%0d got %0d exp %0d", k + 1, capWt[k], k + 1);
            end
        end
        checks++;
        if (fdAtDone !== 1'b1 || wvAtDone !== 1'b0 || rdyAtDone !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_done got fd=%b win=%b rdy=%b exp 1 0 0", fdAtDone, wvAtDone, rdyAtDone);
        end
        checks++;
        if (fdAfter !== 1'b0 || rdyAfter !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_after_done got fd=%b rdy=%b exp 0 1", fdAfter, rdyAfter);
        end
    endtask

    task automatic test_order;
        for (int p = 0; p < NPIX; p++) refPix[p] = 8'($urandom);
        for (int k = 0; k < 9; k++) refWt[k] = 8'($urandom);
        for (int mode = 1; mode <= 2; mode++) begin
            load_frame(mode, 100);
            capture(0);
            checks++;
            if (loadTimeout || capTimeout || loadEndWv !== 1'b0 || firstLat != 1 || nWin != NWIN) begin
                errors++;
                $display("[TB] FAIL order%0d_timing got lat=%0d count=%0d early=%b exp lat=1 count=%0d", mode, firstLat, nWin, loadEndWv, NWIN);
            end
            checks++;
            if (fullRdySeen) begin
                errors++;
                $display("[TB] FAIL order%0d_full_ready got ready=1 after set complete exp 0", mode);
            end
            for (int i = 0; i < NWIN; i++) begin
                int bad;
                bad = -1;
                for (int k = 0; k < 9; k++) if (capWin[i][k] !== expPix(i, k)) bad = k;
                checks++;
                if (bad >= 0) begin
                    errors++;
                    $display("[TB] FAIL order%0d_win%0d k=%0d got %0d exp %0d", mode, i, bad, capWin[i][bad], expPix(i, bad));
                end
            end
            checks++;
            if (capWt[8] !== refWt[8] || capWt[0] !== refWt[0]) begin
                errors++;
                $display("[TB] FAIL order%0d_weights got %0d %0d exp %0d %0d", mode, capWt[0], capWt[8], refWt[0], refWt[8]);
            end
        end
    endtask

    task automatic test_random_valid;
        for (int p = 0; p < NPIX; p++) refPix[p] = 8'($urandom);
        for (int k = 0; k < 9; k++) refWt[k] = 8'($urandom);
        load_frame(0, 50);
        capture(1);
        checks++;
        if (loadTimeout || capTimeout || nWin != NWIN) begin
            errors++;
            $display("[TB] FAIL random_count got %0d exp %0d", nWin, NWIN);
        end
        checks++;
        if (rdyInEmit) begin
            errors++;
            $display("[TB] FAIL random_ready_in_emit got 1 exp 0");
        end
        for (int i = 0; i < NWIN; i++) begin
            int bad;
            bad = -1;
            for (int k = 0; k < 9; k++) if (capWin[i][k] !== expPix(i, k)) bad = k;
            checks++;
            if (bad >= 0) begin
                errors++;
                $display("[TB] FAIL random_win%0d k=%0d got %0d exp %0d", i, bad, capWin[i][bad], expPix(i, bad));
            end
        end
    endtask

    task automatic test_back_to_back;
        for (int f = 0; f < 2; f++) begin
            for (int p = 0; p < NPIX; p++) refPix[p] = 8'(f * 100 + p);
            for (int k = 0; k < 9; k++) refWt[k] = 8'($urandom);
            load_frame(0, 100);
            capture(0);
            checks++;
            if (loadTimeout || capTimeout || nWin != NWIN || fdAtDone !== 1'b1) begin
                errors++;
                $display("[TB] FAIL b2b%0d_count got %0d fd=%b exp %0d 1", f, nWin, fdAtDone, NWIN);
            end
            for (int i = 0; i < NWIN; i++) begin
                int bad;
                bad = -1;
                for (int k = 0; k < 9; k++) if (capWin[i][k] !== expPix(i, k)) bad = k;
                checks++;
                if (bad >= 0) begin
                    errors++;
                    $display("[TB] FAIL b2b%0d_win%0d k=%0d got %0d exp %0d", f, i, bad, capWin[i][bad], expPix(i, bad));
                end
            end
        end
        checks++;
        if (capWin[0][0] !== 8'd100 || capWin[0][3] !== 8'd107) begin
            errors++;
            $display("[TB] FAIL b2b_first_window got %0d %0d exp 100 107", capWin[0][0], capWin[0][3]);
        end
    endtask

    task automatic test_reset_abort;
        for (int p = 0; p < NPIX; p++) refPix[p] = 8'($urandom);
        for (int k = 0; k < 9; k++) refWt[k] = 8'($urandom);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            pixValid = 1'b1; pixData = refPix[c];
            wtValid = (c < 5); wtData = refWt[c % 9];
            @(posedge clk);
        end
        @(negedge clk);
        pixValid = 1'b0; wtValid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (pixReady !== 1'b1 || wtReady !== 1'b1 || winValid !== 1'b0 || wts[0] !== 8'd0) begin
            errors++;
            $display("[TB] FAIL abort_load got pr=%b wr=%b win=%b w1=%h exp 1 1 0 00", pixReady, wtReady, winValid, wts[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int p = 0; p < NPIX; p++) refPix[p] = 8'($urandom);
        for (int k = 0; k < 9; k++) refWt[k] = 8'($urandom);
        load_frame(0, 100);
        @(negedge clk);
        repeat (9) @(negedge clk);
        checks++;
        if (loadTimeout || winValid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_emit_pre got win=%b to=%0d exp 1 0", winValid, loadTimeout);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (winValid !== 1'b0 || win[0] !== 8'd0 || frameDone !== 1'b0 || pixReady !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_emit got win=%b w1=%h fd=%b pr=%b exp 0 00 0 1", winValid, win[0], frameDone, pixReady);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int p = 0; p < NPIX; p++) refPix[p] = 8'($urandom);
        for (int k = 0; k < 9; k++) refWt[k] = 8'($urandom);
        load_frame(0, 100);
        capture(0);
        checks++;
        if (loadTimeout || capTimeout || nWin != NWIN) begin
            errors++;
            $display("[TB] FAIL abort_fresh_count got %0d exp %0d", nWin, NWIN);
        end
        for (int i = 0; i < NWIN; i++) begin
            int bad;
            bad = -1;
            for (int k = 0; k < 9; k++) if (capWin[i][k] !== expPix(i, k)) bad = k;
            checks++;
            if (bad >= 0) begin
                errors++;
                $display("[TB] FAIL abort_fresh_win%0d k=%0d got %0d exp %0d", i, bad, capWin[i][bad], expPix(i, bad));
            end
        end
    endtask

    task automatic test_conv_chain;
        for (int p = 0; p < NPIX; p++) refPix[p] = 8'd255;
        for (int k = 0; k < 9; k++) refWt[k] = 8'd255;
        load_frame(0, 100);
        capture(0);
        checks++;
        if (loadTimeout || capTimeout || nWin != NWIN) begin
            errors++;
            $display("[TB] FAIL conv_count got %0d exp %0d", nWin, NWIN);
        end
        for (int i = 0; i < NWIN; i++) begin
            int sum;
            sum = 0;
            for (int k = 0; k < 9; k++) sum += int'(capWin[i][k]) * int'(capWt[k]);
            checks++;
            if (sum != 585225) begin
                errors++;
                $display("[TB] FAIL conv_out%0d got %0d exp 585225", i, sum);
            end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got no finish exp finish within budget");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        test_reset;
        test_basic;
        test_order;
        test_random_valid;
        test_back_to_back;
        test_reset_abort;
        test_conv_chain;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
